scan_chain_array_fi: RTL
========================

# scan_chain_array_fi

Multi-chain scan register array with parametrised chain count and length, stuck-at fault injection on any flip-flop, and a built-in flush-test engine. It is the generalised successor of the single-chain fault-injection scan model. It sits between the STIL-driven scan bench and the coverage scoreboard and serves as the device under test for chain-integrity and fault-coverage experiments.

## Interface

**Parameters**
- `NUM_CHAINS`, default 4: number of independent scan chains (≥1).
- `CHAIN_LEN`, default 8: flip-flops per chain (≥2).
- Derived widths: `IDX_W = $clog2(CHAIN_LEN)`, `CH_W = max(1, $clog2(NUM_CHAINS))`.

**Ports**
- `sclk`, input, 1: scan clock; single clock domain.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `se`, input, 1: scan enable (shift).
- `cap_en`, input, 1: parallel capture enable; only used when `se`=0.
- `si`, input, NUM_CHAINS: scan-in; bit c feeds chain c.
- `cap_data`, input, NUM_CHAINS*CHAIN_LEN: capture data; bit c*CHAIN_LEN+i loads chain c, FF i.
- `so`, output, NUM_CHAINS: scan-out; bit c is the observed FF CHAIN_LEN-1 of chain c.
- `q_out`, output, NUM_CHAINS*CHAIN_LEN: observed state of every FF, same indexing as `cap_data`.
- `fault_en`, input, 1: enables fault injection.
- `fault_chain`, input, CH_W: target chain.
- `fault_idx`, input, IDX_W: target FF (0 = next to si).
- `fault_sa_value`, input, 1: 0 = SA0, 1 = SA1.
- `fault_mode`, input, 1: 0 = observe-only, 1 = state (corrupts the shift path).
- `flush_start`, input, 1: one-cycle request to start a flush test.
- `flush_busy`, output, 1: flush in progress.
- `flush_done`, output, 1: one-cycle pulse when the flush completes.
- `flush_fail`, output, NUM_CHAINS: per-chain mismatch flag, held until the next start.
- `flush_first_fail`, output, 3: pattern index of the first mismatch on any chain.

## Operation

- **Storage**
  - `q[c][i]` holds the true register state. FF i shifts into FF i+1.
  - The effective value `e[c][i]` equals `q[c][i]`, except that it is replaced by `fault_sa_value` when all of these hold: `fault_en`, `fault_mode`=1, `fault_chain`=c, and `fault_idx`=i.
- **Observed value per FF**
  - Equal to `e`, except that it is forced to `fault_sa_value` when `fault_en`, `fault_mode`=0, and the chain/index match.
  - `q_out` and `so` (observed FF CHAIN_LEN-1) both show the observed value.
- **Shift datapath**
  - Shifting uses `e`, so a state-mode fault propagates downstream.
  - An observe-only fault never alters `q`.
- **Fault range**
  - An out-of-range `fault_chain` or `fault_idx` injects nothing.
  - Removing the fault restores the true `q` value immediately. Bits already shifted past a state-mode fault stay corrupted.
- **Priority on each `sclk` edge, while FSM is IDLE**
  - `se`=1: shift, with `si[c]` entering FF 0.
  - Else `cap_en`=1: `q` ← `cap_data`.
  - Else: hold.
- **Flush FSM states: IDLE, FLUSH**
  - IDLE→FLUSH on `flush_start`. This clears `flush_fail`, `flush_first_fail` and counter k.
  - In FLUSH:
    - All chains shift every cycle, regardless of `se`/`cap_en`/`si`.
    - The internal si for every chain is `pat(k) = (k>>1)&1`, giving the sequence 0,0,1,1,…
    - For k in CHAIN_LEN..CHAIN_LEN+7, `so[c]` is compared with `pat(k-CHAIN_LEN)`.
    - On a mismatch, `flush_fail[c]` is set. On the first mismatch of the run, `flush_first_fail` = k-CHAIN_LEN.
    - k increments each cycle.
  - FLUSH→IDLE after the cycle with k = CHAIN_LEN+7. `flush_done` pulses in the first IDLE cycle.
  - `flush_start` while busy is ignored.
- **Post-flush state**
  - The chain holds the last CHAIN_LEN pattern bits.
  - Results are held until the next `flush_start`.

## Timing

- **Reset (asynchronous, `rst_n`=0)**
  - `q` = 0, FSM in IDLE, k = 0.
  - `flush_busy`/`flush_done` = 0, `flush_fail` = 0, `flush_first_fail` = 0.
  - `so`/`q_out` = 0 unless forced by an active fault.
- **Reset mid-flush:** aborts the test immediately. No `flush_done` pulse is produced.
- **Combinational outputs:** `so` and `q_out` are combinational from `q` and the fault controls. Fault changes are visible in the same cycle.
- **Shift/capture:** one cycle of latency; the new value is visible after the `sclk` edge.
- **Flush run:** `flush_busy` rises on the edge that samples `flush_start` and stays high for exactly CHAIN_LEN+8 cycles.
- **Flush results:** `flush_fail` and `flush_first_fail` are registered and final by the cycle `flush_done` is high.
- **Simultaneous inputs:** `se` and `cap_en` together means shift wins. `flush_start` overrides both `se` and `cap_en` from the next edge.

## Test plan

- **Shift, no fault:** defaults; shift 8'b1011_0010 into chain 2 with 8 `se` cycles, then 8 more cycles → `so[2]` returns the same bits in order. Other chains, driven with si=0, output 0.
- **Capture:** `se`=0, `cap_en`=1, `cap_data`=all-ones except bit 9 → next cycle `q_out` matches. Then 7 shifts with si=0 → `so[1]` equals 1,1,1,1,1,1,0 … (bit 9 = chain 1 FF 1 exits last).
- **Observe-only fault:** chain 0, idx 3, SA1, mode 0, chain loaded with 0 → `q_out[3]`=1, `so[0]`=0. After 8 shifts with si=0, `so[0]` stays 0 and `q` is unchanged.
- **State-fault flush:** chain 1, idx 5, mode 1, SA0; pulse `flush_start` → busy for 16 cycles, done pulse, `flush_fail`=4'b0010, `flush_first_fail`=2. Same test with SA1 → `flush_first_fail`=0.
- **Clean flush and abort:**
  - No fault → `flush_fail`=0 at done.
  - Restart and assert `rst_n`=0 at k=5 → busy drops immediately, no done pulse, all outputs at reset values.
- **Ignored start:** `flush_start` asserted again at k=3 → no restart; total busy length is still 16 cycles.

Source files
------------

// File: rtl/scan_chain_array_fi.sv
// Multi-chain scan register array with stuck-at fault injection on any flip-flop
// and a built-in flush-test engine that drives a 0,0,1,1 pattern through every chain.
module scan_chain_array_fi #(
  parameter int unsigned NUM_CHAINS = 4,
  parameter int unsigned CHAIN_LEN  = 8,
  localparam int unsigned IDX_W     = $clog2(CHAIN_LEN),
  localparam int unsigned CH_W      = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
  input  logic                            sclk,
  input  logic                            rst_n,
  input  logic                            se,
  input  logic                            cap_en,
  input  logic [NUM_CHAINS-1:0]           si,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0] cap_data,
  output logic [NUM_CHAINS-1:0]           so,
  output logic [NUM_CHAINS*CHAIN_LEN-1:0] q_out,
  input  logic                            fault_en,
  input  logic [CH_W-1:0]                 fault_chain,
  input  logic [IDX_W-1:0]                fault_idx,
  input  logic                            fault_sa_value,
  input  logic                            fault_mode,
  input  logic                            flush_start,
  output logic                            flush_busy,
  output logic                            flush_done,
  output logic [NUM_CHAINS-1:0]           flush_fail,
  output logic [2:0]                      flush_first_fail
);

  localparam int unsigned NBits = NUM_CHAINS * CHAIN_LEN;
  localparam int unsigned KW    = $clog2(CHAIN_LEN + 8);
  localparam logic [KW-1:0] KCmp  = KW'(CHAIN_LEN);
  localparam logic [KW-1:0] KLast = KW'(CHAIN_LEN + 7);

  typedef enum logic {StIdle, StFlush} state_e;

  state_e                  state_q;
  logic [KW-1:0]           k_q;
  logic [KW-1:0]           k_rel;
  logic                    busy_q;
  logic                    done_q;
  logic [NUM_CHAINS-1:0]   fail_q;
  logic [2:0]              first_q;

  logic [NBits-1:0]        q_q;
  logic [NBits-1:0]        q_d;
  logic [NBits-1:0]        eff;
  logic [NBits-1:0]        obs;
  logic [NUM_CHAINS-1:0]   shift_in;
  logic [NUM_CHAINS-1:0]   mis;

  // State-mode faults alter both the shift path and the view; observe-only faults
  // only alter the view, so obs is forced in either mode.
  always_comb begin
    eff = q_q;
    obs = q_q;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        if (fault_en && (int'(fault_chain) == c) && (int'(fault_idx) == i)) begin
          if (fault_mode) eff[c*CHAIN_LEN+i] = fault_sa_value;
          obs[c*CHAIN_LEN+i] = fault_sa_value;
        end
      end
    end
  end

  always_comb begin
    so = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      so[c] = obs[c*CHAIN_LEN+CHAIN_LEN-1];
    end
  end

  assign q_out = obs;
  assign k_rel = k_q - KCmp;

  always_comb begin
    shift_in = (state_q == StFlush) ? {NUM_CHAINS{k_q[1]}} : si;
  end

  always_comb begin
    q_d = q_q;
    if ((state_q == StFlush) || se) begin
      for (int c = 0; c < NUM_CHAINS; c++) begin
        q_d[c*CHAIN_LEN] = shift_in[c];
        for (int i = 1; i < CHAIN_LEN; i++) begin
          q_d[c*CHAIN_LEN+i] = eff[c*CHAIN_LEN+i-1];
        end
      end
    end else if (cap_en) begin
      q_d = cap_data;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Expected scan-out lags the injected pattern by exactly CHAIN_LEN cycles.
  always_comb begin
    mis = '0;
    for (int c = 0; c < NUM_CHAINS; c++) begin
      mis[c] = so[c] ^ k_rel[1];
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= '0;
      first_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush_start) begin
            state_q <= StFlush;
            busy_q  <= 1'b1;
            k_q     <= '0;
            fail_q  <= '0;
            first_q <= '0;
          end
        end
        StFlush: begin
          if (k_q >= KCmp) begin
            fail_q <= fail_q | mis;
            if ((fail_q == '0) && (mis != '0)) first_q <= k_rel[2:0];
          end
          if (k_q == KLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign flush_busy       = busy_q;
  assign flush_done       = done_q;
  assign flush_fail       = fail_q;
  assign flush_first_fail = first_q;

endmodule
